pipe_stage_reg: RTL

Generic, parametrised pipeline-stage register that replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. It carries a control field and a data field across a stage boundary under a valid/ready handshake, and supports stall (back-pressure) and flush (bubble insertion). Control bits are forced to zero whenever the stage holds a bubble, so a flushed slot can never write registers or memory. A saturating stall counter supports performance debug.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_skid_buf.sv | 62 ++++++
 rtl/pipe_stage_reg.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types and default widths for the pipeline-stage register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_TWO   = 2'd2
    } pipe_state_e;

    localparam int PIPE_CTRL_W = 6;
    localparam int PIPE_DATA_W = 165;
    localparam int PIPE_CNT_W  = 16;

    // A bubble carries no side effects: every control strobe is low.
    localparam logic [PIPE_CTRL_W-1:0] PIPE_BUBBLE_CTRL = '0;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// ============================================================================
// Module   : pipe_skid_buf
// Brief    : Second (skid) entry of the stage; used only when PIPE_SKID_EN is set.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_skid_buf #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 165
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush_i,
    input  logic              Load_i,
    input  logic              Pop_i,
    input  logic [CTRL_W-1:0] Ctrl_i,
    input  logic [DATA_W-1:0] Data_i,
    output logic              Valid_o,
    output logic              Valid_Next_o,
    output logic [CTRL_W-1:0] Ctrl_o,
    output logic [DATA_W-1:0] Data_o
);

    logic              valid_q;
    logic              valid_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        valid_d = valid_q;
        if (Flush_i) begin
            valid_d = 1'b0;
        end else if (Load_i) begin
            valid_d = 1'b1;
        end else if (Pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (Load_i && !Flush_i) begin
                ctrl_q <= Ctrl_i;
                data_q <= Data_i;
            end
        end
    end

    assign Valid_o      = valid_q;
    assign Valid_Next_o = valid_d;
    assign Ctrl_o       = ctrl_q;
    assign Data_o       = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Valid/ready pipeline-stage register with flush, bubble-zeroed
//            control and a saturating stall counter. Optional skid entry
//            (registered In_Ready) is enabled by defining PIPE_SKID_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [CNT_W-1:0]  Stall_Cnt
);

    localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(PIPE_BUBBLE_CTRL);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              drain;

    assign drain = main_valid_q & Out_Ready;

`ifdef PIPE_SKID_EN
    logic              in_ready_q;
    logic              skid_valid;
    logic              skid_valid_next;
    logic              skid_load;
    logic              skid_pop;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    pipe_state_e       state;

    assign In_Ready = in_ready_q;
    assign accept   = In_Valid & in_ready_q & ~Flush;
    assign state    = skid_valid   ? PIPE_TWO :
                      main_valid_q ? PIPE_ONE : PIPE_EMPTY;

    always_comb begin
        main_valid_d = main_valid_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        skid_load    = 1'b0;
        skid_pop     = 1'b0;
        case (state)
            PIPE_EMPTY: begin
                if (accept) begin
                    main_valid_d = 1'b1;
                    ctrl_d       = In_Ctrl;
                    data_d       = In_Data;
                end
            end
            PIPE_ONE: begin
                if (accept && drain) begin
                    ctrl_d = In_Ctrl;
                    data_d = In_Data;
                end else if (accept) begin
                    skid_load = 1'b1;
                end else if (drain) begin
                    main_valid_d = 1'b0;
                    ctrl_d       = BUBBLE;
                end
            end
            PIPE_TWO: begin
                // In_Ready is low here, so only the skid-to-main shift can occur.
                if (drain) begin
                    ctrl_d   = skid_ctrl;
                    data_d   = skid_data;
                    skid_pop = 1'b1;
                end
            end
            default: begin
                main_valid_d = 1'b0;
                ctrl_d       = BUBBLE;
            end
        endcase
        if (Flush) begin
            main_valid_d = 1'b0;
            ctrl_d       = BUBBLE;
            skid_load    = 1'b0;
        end
    end

    pipe_skid_buf #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .Clk          (Clk),
        .Rst          (Rst),
        .Flush_i      (Flush),
        .Load_i       (skid_load),
        .Pop_i        (skid_pop),
        .Ctrl_i       (In_Ctrl),
        .Data_i       (In_Data),
        .Valid_o      (skid_valid),
        .Valid_Next_o (skid_valid_next),
        .Ctrl_o       (skid_ctrl),
        .Data_o       (skid_data)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= ~skid_valid_next & ~Flush;
        end
    end
`else
    assign In_Ready = ~Flush & (~main_valid_q | Out_Ready);
    assign accept   = In_Valid & In_Ready;

    always_comb begin
        main_valid_d = main_valid_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        if (accept) begin
            main_valid_d = 1'b1;
            ctrl_d       = In_Ctrl;
            data_d       = In_Data;
        end else if (drain) begin
            main_valid_d = 1'b0;
            ctrl_d       = BUBBLE;
        end
        if (Flush) begin
            main_valid_d = 1'b0;
            ctrl_d       = BUBBLE;
        end
    end
`endif

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (main_valid_q && !Out_Ready && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            main_valid_q <= 1'b0;
            ctrl_q       <= BUBBLE;
            data_q       <= '0;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
        end
    end

    assign Out_Valid = main_valid_q;
    assign Out_Ctrl  = ctrl_q;
    assign Out_Data  = data_q;
    assign Stall_Cnt = cnt_q;

endmodule

`default_nettype wire
